// File: rtl/xm_mem_arbiter.sv
// xm_mem_arbiter: shares one memory port between CPU and DMA/debug.
// Fixed CPU priority, DMA starvation guard, per-access timeout.
module xm_mem_arbiter #(
  parameter int WORD    = 16,
  parameter int STARVE  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic            clk_i,
  input  logic            arst_i,
  input  logic            cpuEn_i,
  input  logic            cpuRW_i,
  input  logic            cpuByte_i,
  input  logic [WORD-1:0] cpuAddr_i,
  input  logic [WORD-1:0] cpuWrData_i,
  output logic            cpuBusy_o,
  output logic            cpuAck_o,
  output logic [WORD-1:0] cpuRdData_o,
  input  logic            dmaEn_i,
  input  logic            dmaRW_i,
  input  logic            dmaByte_i,
  input  logic [WORD-1:0] dmaAddr_i,
  input  logic [WORD-1:0] dmaWrData_i,
  output logic            dmaAck_o,
  output logic [WORD-1:0] dmaRdData_o,
  output logic            memEn_o,
  output logic            memRW_o,
  output logic            memByte_o,
  output logic [WORD-1:0] memAddr_o,
  output logic [WORD-1:0] memWrData_o,
  input  logic [WORD-1:0] memRdData_i,
  input  logic            memAck_i,
  output logic            errPulse_o
);

  typedef enum logic [1:0] {
    IDLE,
    ACC_CPU,
    ACC_DMA,
    DONE
  } state_t;

  localparam logic [7:0] STARVE_L = 8'(STARVE);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t    state;
  state_t    stateNext;
  logic      ownDma;
  logic [7:0] starveCnt;
  logic [7:0] tmoCnt;

  logic grantDma;
  logic grantCpu;
  logic inAcc;
  logic tmoHit;
  logic finish;
  logic dmaServiced;
  logic [WORD-1:0] rdVal;

  always_comb begin
    grantDma    = 1'b0;
    grantCpu    = 1'b0;
    inAcc       = 1'b0;
    tmoHit      = 1'b0;
    finish      = 1'b0;
    dmaServiced = 1'b0;
    stateNext   = state;
    memEn_o     = 1'b0;
    cpuAck_o    = 1'b0;
    dmaAck_o    = 1'b0;
    errPulse_o  = 1'b0;
    cpuBusy_o   = 1'b0;
    rdVal       = memAck_i ? memRdData_i : '1;

    grantDma = dmaEn_i & ((starveCnt >= STARVE_L) | ~cpuEn_i);
    grantCpu = cpuEn_i & ~grantDma;
    inAcc    = (state == ACC_CPU) | (state == ACC_DMA);
    // memAck takes precedence over an expiring timeout
    tmoHit   = inAcc & ~memAck_i & (tmoCnt == TMO_LAST);
    finish   = inAcc & (memAck_i | tmoHit);

    unique case (state)
      IDLE: begin
        if (grantDma) stateNext = ACC_DMA;
        else if (grantCpu) stateNext = ACC_CPU;
        dmaServiced = grantDma;
      end
      ACC_CPU: if (finish) stateNext = DONE;
      ACC_DMA: begin
        if (finish) stateNext = DONE;
        dmaServiced = 1'b1;
      end
      DONE: begin
        stateNext   = IDLE;
        dmaServiced = ownDma;
      end
    endcase

    memEn_o    = inAcc;
    cpuAck_o   = (state == DONE) & ~ownDma;
    dmaAck_o   = (state == DONE) & ownDma;
    errPulse_o = tmoHit;
    cpuBusy_o  = cpuEn_i & ~cpuAck_o;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state       <= IDLE;
      ownDma      <= 1'b0;
      starveCnt   <= '0;
      tmoCnt      <= '0;
      memRW_o     <= 1'b0;
      memByte_o   <= 1'b0;
      memAddr_o   <= '0;
      memWrData_o <= '0;
      cpuRdData_o <= '0;
      dmaRdData_o <= '0;
    end else begin
      state <= stateNext;

      if (!dmaEn_i || dmaServiced) starveCnt <= '0;
      else if (starveCnt != 8'hFF) starveCnt <= starveCnt + 8'd1;

      if (inAcc) tmoCnt <= tmoCnt + 8'd1;
      else tmoCnt <= '0;

      if (state == IDLE && grantDma) begin
        ownDma      <= 1'b1;
        memRW_o     <= dmaRW_i;
        memByte_o   <= dmaByte_i;
        memAddr_o   <= dmaAddr_i;
        memWrData_o <= dmaWrData_i;
      end else if (state == IDLE && grantCpu) begin
        ownDma      <= 1'b0;
        memRW_o     <= cpuRW_i;
        memByte_o   <= cpuByte_i;
        memAddr_o   <= cpuAddr_i;
        memWrData_o <= cpuWrData_i;
      end

      // writes leave the read-data registers untouched
      if (finish && !memRW_o) begin
        if (ownDma) dmaRdData_o <= rdVal;
        else cpuRdData_o <= rdVal;
      end
    end
  end

endmodule

// File: tb/tb_xm_mem_arbiter.sv
// tb_xm_mem_arbiter: directed scenarios plus random traffic,
// checked every cycle against a behavioural reference model.
module tb_xm_mem_arbiter;

  localparam int WORD    = 16;
  localparam int STARVE  = 8;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic arst;
  logic cpuEn, cpuRW, cpuByte;
  logic [WORD-1:0] cpuAddr, cpuWrData;
  logic cpuBusy, cpuAck;
  logic [WORD-1:0] cpuRdData;
  logic dmaEn, dmaRW, dmaByte;
  logic [WORD-1:0] dmaAddr, dmaWrData;
  logic dmaAck;
  logic [WORD-1:0] dmaRdData;
  logic memEn, memRW, memByte;
  logic [WORD-1:0] memAddr, memWrData;
  logic [WORD-1:0] memRdData;
  logic memAck;
  logic errPulse;

  xm_mem_arbiter #(
    .WORD(WORD), .STARVE(STARVE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk), .arst_i(arst),
    .cpuEn_i(cpuEn), .cpuRW_i(cpuRW), .cpuByte_i(cpuByte),
    .cpuAddr_i(cpuAddr), .cpuWrData_i(cpuWrData),
    .cpuBusy_o(cpuBusy), .cpuAck_o(cpuAck), .cpuRdData_o(cpuRdData),
    .dmaEn_i(dmaEn), .dmaRW_i(dmaRW), .dmaByte_i(dmaByte),
    .dmaAddr_i(dmaAddr), .dmaWrData_i(dmaWrData),
    .dmaAck_o(dmaAck), .dmaRdData_o(dmaRdData),
    .memEn_o(memEn), .memRW_o(memRW), .memByte_o(memByte),
    .memAddr_o(memAddr), .memWrData_o(memWrData),
    .memRdData_i(memRdData), .memAck_i(memAck),
    .errPulse_o(errPulse)
  );

  always #5 clk = ~clk;

  int nTests = 0;
  int nFail  = 0;

  task automatic check(string tag, logic [39:0] got, logic [39:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model: who owns the port, how far along the access is
  int mPhase;   // 0 free, 1 memory busy, 2 completing
  int mOwner;   // 0 cpu, 1 dma
  int mCnt;
  int mStarve;
  logic mRW, mByte;
  logic [WORD-1:0] mAddr, mWd, mCpuRd, mDmaRd;

  bit randMode = 0;
  bit cpuHold  = 0;
  bit forceAck = 0;
  int ackDelay = 0;
  logic [WORD-1:0] rdVal = '0;
  int cpuAckCnt, dmaAckCnt, errCnt, memEnCnt, firstOwner;

  task automatic modelReset();
    mPhase = 0; mOwner = 0; mCnt = 0; mStarve = 0;
    mRW = 0; mByte = 0; mAddr = '0; mWd = '0;
    mCpuRd = '0; mDmaRd = '0;
  endtask

  task automatic store(logic [WORD-1:0] v);
    if (mOwner == 0) mCpuRd = v;
    else mDmaRd = v;
  endtask

  task automatic tick();
    bit eMemEn, eCpuAck, eDmaAck, eErr;
    int pick;
    memAck = (mPhase == 1 && mCnt == ackDelay) || forceAck;
    if (randMode && mPhase != 1 && $urandom_range(7) == 0) memAck = 1;
    memRdData = randMode ? WORD'($urandom) : rdVal;
    #1;
    eMemEn  = (mPhase == 1);
    eCpuAck = (mPhase == 2 && mOwner == 0);
    eDmaAck = (mPhase == 2 && mOwner == 1);
    eErr    = (mPhase == 1 && !memAck && mCnt == TIMEOUT - 1);
    check("memEn", 40'(memEn), 40'(eMemEn));
    check("cpuAck", 40'(cpuAck), 40'(eCpuAck));
    check("dmaAck", 40'(dmaAck), 40'(eDmaAck));
    check("errPulse", 40'(errPulse), 40'(eErr));
    check("cpuBusy", 40'(cpuBusy), 40'(cpuEn & ~eCpuAck));
    check("cpuRdData", 40'(cpuRdData), 40'(mCpuRd));
    check("dmaRdData", 40'(dmaRdData), 40'(mDmaRd));
    check("memBundle", 40'({memRW, memByte, memAddr, memWrData}),
          40'({mRW, mByte, mAddr, mWd}));
    if (eCpuAck) cpuAckCnt++;
    if (eDmaAck) dmaAckCnt++;
    if (eErr) errCnt++;
    if (eMemEn) memEnCnt++;
    if ((eCpuAck || eDmaAck) && firstOwner < 0) firstOwner = eDmaAck ? 1 : 0;

    pick = -1;
    case (mPhase)
      0: begin
        if (dmaEn && mStarve >= STARVE) pick = 1;
        else if (cpuEn) pick = 0;
        else if (dmaEn) pick = 1;
        if (!dmaEn || pick == 1) mStarve = 0;
        else if (mStarve < 255) mStarve++;
        if (pick >= 0) begin
          mOwner = pick;
          mRW   = pick ? dmaRW : cpuRW;
          mByte = pick ? dmaByte : cpuByte;
          mAddr = pick ? dmaAddr : cpuAddr;
          mWd   = pick ? dmaWrData : cpuWrData;
          mPhase = 1;
          mCnt = 0;
          if (randMode)
            ackDelay = ($urandom_range(19) == 0) ? 255 : int'($urandom_range(3));
        end
      end
      1: begin
        if (!dmaEn || mOwner == 1) mStarve = 0;
        else if (mStarve < 255) mStarve++;
        if (memAck) begin
          if (!mRW) store(memRdData);
          mPhase = 2;
        end else if (mCnt == TIMEOUT - 1) begin
          if (!mRW) store('1);
          mPhase = 2;
        end else mCnt++;
      end
      default: begin
        if (!dmaEn || mOwner == 1) mStarve = 0;
        else if (mStarve < 255) mStarve++;
        mPhase = 0;
      end
    endcase

    @(negedge clk);
    if (eCpuAck && !cpuHold) cpuEn = 0;
    if (eDmaAck) dmaEn = 0;
  endtask

  task automatic waitIdle(string tag, int budget);
    int n = 0;
    while ((cpuEn || dmaEn || mPhase != 0) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_bound"}, 40'(n < budget), 40'd1);
  endtask

  logic [WORD-1:0] saved;

  initial begin
    arst = 1; cpuEn = 0; cpuRW = 0; cpuByte = 0; cpuAddr = '0; cpuWrData = '0;
    dmaEn = 0; dmaRW = 0; dmaByte = 0; dmaAddr = '0; dmaWrData = '0;
    memAck = 0; memRdData = '0;
    modelReset();
    cpuAckCnt = 0; dmaAckCnt = 0; errCnt = 0; memEnCnt = 0; firstOwner = -1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_memEn", 40'(memEn), 40'd0);
    check("rst_acks", 40'({cpuAck, dmaAck, errPulse}), 40'd0);
    check("rst_rd", 40'({cpuRdData, dmaRdData}), 40'd0);
    @(negedge clk);
    arst = 0;

    // CPU read 0x0040, ack one cycle after memEn rises
    ackDelay = 1; rdVal = 16'hBEEF;
    cpuEn = 1; cpuRW = 0; cpuAddr = 16'h0040;
    waitIdle("t1", 50);
    check("t1_rd", 40'(cpuRdData), 40'h0BEEF);
    check("t1_addr", 40'(memAddr), 40'h00040);
    check("t1_acks", 40'(cpuAckCnt), 40'd1);

    // simultaneous requests: CPU first, then DMA
    ackDelay = 0; firstOwner = -1; cpuAckCnt = 0; dmaAckCnt = 0;
    rdVal = 16'h5A5A;
    cpuEn = 1; cpuAddr = 16'h0044;
    dmaEn = 1; dmaRW = 0; dmaAddr = 16'h0200;
    waitIdle("t2", 50);
    check("t2_first", 40'(firstOwner), 40'd0);
    check("t2_dmaAcks", 40'(dmaAckCnt), 40'd1);
    check("t2_dmaRd", 40'(dmaRdData), 40'h05A5A);

    // continuous CPU traffic: DMA wins after three CPU accesses
    cpuHold = 1; cpuAckCnt = 0; dmaAckCnt = 0;
    cpuEn = 1; dmaEn = 1; dmaAddr = 16'h0208;
    for (int i = 0; i < 200 && dmaAckCnt == 0; i++) tick();
    check("t3_dmaAck", 40'(dmaAckCnt), 40'd1);
    check("t3_cpuBefore", 40'(cpuAckCnt), 40'd3);
    cpuHold = 0;
    waitIdle("t3", 50);

    // DMA write with no memory ack times out
    saved = dmaRdData;
    ackDelay = 255; memEnCnt = 0; errCnt = 0;
    dmaEn = 1; dmaRW = 1; dmaAddr = 16'h0100; dmaWrData = 16'h1234;
    waitIdle("t4w", 200);
    check("t4_memEnCycles", 40'(memEnCnt), 40'd64);
    check("t4_err", 40'(errCnt), 40'd1);
    check("t4_rdKept", 40'(dmaRdData), 40'(saved));
    dmaEn = 1; dmaRW = 0;
    waitIdle("t4r", 200);
    check("t4_rdOnes", 40'(dmaRdData), 40'h0FFFF);
    check("t4_err2", 40'(errCnt), 40'd2);

    // async reset in the middle of a CPU access
    ackDelay = 255;
    cpuEn = 1; cpuRW = 0; cpuAddr = 16'h0300;
    repeat (3) tick();
    arst = 1;
    #1;
    check("t5_memEn", 40'(memEn), 40'd0);
    check("t5_acks", 40'({cpuAck, dmaAck, errPulse}), 40'd0);
    check("t5_mem", 40'({memRW, memByte, memAddr, memWrData}), 40'd0);
    check("t5_rd", 40'({cpuRdData, dmaRdData}), 40'd0);
    modelReset();
    @(negedge clk);
    arst = 0;
    ackDelay = 0; memEnCnt = 0;
    tick();
    check("t5_grantCycle", 40'(memEnCnt), 40'd0);
    tick();
    check("t5_memEnNext", 40'(memEnCnt), 40'd1);
    waitIdle("t5", 50);

    // stray memAck while idle
    saved = cpuRdData; cpuAckCnt = 0; dmaAckCnt = 0;
    rdVal = 16'h7777; forceAck = 1;
    repeat (4) tick();
    forceAck = 0;
    check("t6_noAck", 40'(cpuAckCnt + dmaAckCnt), 40'd0);
    check("t6_rdKept", 40'(cpuRdData), 40'(saved));

    // random traffic
    randMode = 1;
    for (int i = 0; i < 3000; i++) begin
      if (!cpuEn && $urandom_range(3) == 0) begin
        cpuEn = 1; cpuRW = 1'($urandom); cpuByte = 1'($urandom);
        cpuAddr = WORD'($urandom); cpuWrData = WORD'($urandom);
      end
      if (!dmaEn && $urandom_range(3) == 0) begin
        dmaEn = 1; dmaRW = 1'($urandom); dmaByte = 1'($urandom);
        dmaAddr = WORD'($urandom); dmaWrData = WORD'($urandom);
      end
      tick();
    end
    randMode = 0;
    ackDelay = 0;
    waitIdle("rand", 300);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
